// File: rtl/pipe_pkg.sv
// Shared core definitions: sequencer state encoding, per-stage control bundle
// and the register index width used across the pipeline.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } pipe_state_e;

  // Load enables and bubble controls for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, MEM-resolved branch flushes and
// data-memory waits with a timeout watchdog, plus saturating statistics.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = pipe_pkg::REG_ADDR_W,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  mem_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  ex_mem_write,
  output logic                  mem_wb_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output pipe_state_e           state_dbg,
  output logic [$clog2(MEM_TIMEOUT)-1:0] wait_cnt_dbg
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  pipe_state_e    state;
  logic [WCW-1:0] wait_cnt;
  pipe_ctrl_t     ctrl;
  logic           memstall;
  logic           loaduse;
  logic           stall_inc;
  logic           flush_inc;

  // Memory handshake: the access is outstanding while mem_req=1 and completes
  // in the cycle mem_ready=1; dropping mem_req without ready also ends it.
  assign memstall = mem_req & ~mem_ready;

  assign loaduse = ex_mem_read && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    ctrl      = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                  ex_mem_write: 1'b1, mem_wb_write: 1'b1, default: 1'b0};
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (reset) begin
      ctrl = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
               mem_wb_flush: 1'b1, default: 1'b0};
    end else if (state == ERR) begin
      ctrl = '0;
    end else if (memstall) begin
      // Everything upstream holds; a bubble drains into WB.
      ctrl              = '0;
      ctrl.mem_wb_write = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
      stall_inc         = 1'b1;
    end else if (mem_branch_taken) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
      flush_inc         = 1'b1;
    end else if (loaduse) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.id_ex_flush = 1'b1;
      stall_inc        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memstall) begin
            state    <= WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        WAIT: begin
          if (!memstall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_write  = ctrl.id_ex_write;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_write = ctrl.mem_wb_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign mem_err      = ~reset & (state == ERR);
  assign state_dbg    = state;
  assign wait_cnt_dbg = wait_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with small timeout and counter width so
// the watchdog and saturation corners are reachable in a few cycles.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int RW = 5;
  localparam int CW = 3;
  localparam int TO = 4;

  // control vector order: {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w,
  //                        if_id_f, id_ex_f, ex_mem_f, mem_wb_f}
  localparam logic [8:0] V_NORMAL = 9'b11111_0000;
  localparam logic [8:0] V_LDUSE  = 9'b00111_0100;
  localparam logic [8:0] V_BRANCH = 9'b11111_1110;
  localparam logic [8:0] V_MEMST  = 9'b00001_0001;
  localparam logic [8:0] V_RESET  = 9'b00000_1111;
  localparam logic [8:0] V_FREEZE = 9'b00000_0000;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read;
  logic mem_branch_taken, mem_req, mem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  pipe_state_e state_dbg;
  logic [$clog2(TO)-1:0] wait_cnt_dbg;
  logic [8:0] ctrl_v;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg)
  );

  assign ctrl_v = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs checked 1ns later
  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_loaduse(input logic [RW-1:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_use_rs2 = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk); #1;

    // reset state
    check("reset_ctrl", int'(ctrl_v), int'(V_RESET));
    check("reset_err", int'(mem_err), 0);
    next_cycle();
    check("reset_state", int'(state_dbg), int'(RUN));
    check("reset_stall_cnt", int'(stall_cnt), 0);
    check("reset_flush_cnt", int'(flush_cnt), 0);
    reset = 1'b0;
    #1;
    check("idle_ctrl", int'(ctrl_v), int'(V_NORMAL));

    // load-use on rs2
    set_loaduse(5'd5);
    #1;
    check("lu_rs2_ctrl", int'(ctrl_v), int'(V_LDUSE));
    next_cycle();
    check("lu_rs2_cnt", int'(stall_cnt), 1);
    // destination x0 never stalls
    set_loaduse(5'd0);
    #1;
    check("lu_x0_ctrl", int'(ctrl_v), int'(V_NORMAL));
    next_cycle();
    check("lu_x0_cnt", int'(stall_cnt), 1);
    // rs1 match, then same match without the use flag
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1;
    check("lu_rs1_ctrl", int'(ctrl_v), int'(V_LDUSE));
    next_cycle();
    check("lu_rs1_cnt", int'(stall_cnt), 2);
    id_use_rs1 = 1'b0;
    #1;
    check("lu_nouse_ctrl", int'(ctrl_v), int'(V_NORMAL));
    // not a load
    id_use_rs1 = 1'b1; ex_mem_read = 1'b0;
    #1;
    check("lu_noload_ctrl", int'(ctrl_v), int'(V_NORMAL));
    next_cycle();

    // branch flush, then branch together with load-use
    idle_inputs();
    mem_branch_taken = 1'b1;
    #1;
    check("br_ctrl", int'(ctrl_v), int'(V_BRANCH));
    next_cycle();
    check("br_flush_cnt", int'(flush_cnt), 1);
    set_loaduse(5'd9);
    #1;
    check("br_lu_ctrl", int'(ctrl_v), int'(V_BRANCH));
    next_cycle();
    check("br_lu_flush_cnt", int'(flush_cnt), 2);
    check("br_lu_stall_cnt", int'(stall_cnt), 2);

    // memory wait: three stalled cycles then completion
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      mem_branch_taken = (i == 2);
      #1;
      check($sformatf("mw_ctrl_%0d", i), int'(ctrl_v), int'(V_MEMST));
      next_cycle();
      check($sformatf("mw_state_%0d", i), int'(state_dbg), int'(WAIT));
      check($sformatf("mw_wcnt_%0d", i), int'(wait_cnt_dbg), i);
    end
    mem_branch_taken = 1'b0;
    check("mw_flush_cnt", int'(flush_cnt), 0);
    mem_ready = 1'b1;
    #1;
    check("mw_done_ctrl", int'(ctrl_v), int'(V_NORMAL));
    next_cycle();
    check("mw_done_state", int'(state_dbg), int'(RUN));
    check("mw_done_wcnt", int'(wait_cnt_dbg), 0);
    check("mw_stall_cnt", int'(stall_cnt), 3);

    // mem_req drops without ready: treated as completion
    mem_req = 1'b1; mem_ready = 1'b0;
    next_cycle();
    mem_req = 1'b0;
    #1;
    check("mw_drop_ctrl", int'(ctrl_v), int'(V_NORMAL));
    next_cycle();
    check("mw_drop_state", int'(state_dbg), int'(RUN));

    // timeout with MEM_TIMEOUT=4
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("to_ctrl_%0d", i), int'(ctrl_v), int'(V_MEMST));
      check($sformatf("to_err_%0d", i), int'(mem_err), 0);
      next_cycle();
    end
    check("to_state", int'(state_dbg), int'(ERR));
    check("to_err", int'(mem_err), 1);
    check("to_ctrl", int'(ctrl_v), int'(V_FREEZE));
    check("to_stall_cnt", int'(stall_cnt), 4);
    mem_ready = 1'b1; mem_branch_taken = 1'b1;
    next_cycle();
    check("to_sticky_state", int'(state_dbg), int'(ERR));
    check("to_sticky_err", int'(mem_err), 1);
    check("to_sticky_ctrl", int'(ctrl_v), int'(V_FREEZE));
    check("to_sticky_flush_cnt", int'(flush_cnt), 0);
    reset = 1'b1;
    #1;
    check("to_rst_err", int'(mem_err), 0);
    check("to_rst_ctrl", int'(ctrl_v), int'(V_RESET));
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    #1;
    check("to_rst_state", int'(state_dbg), int'(RUN));
    check("to_rst_stall_cnt", int'(stall_cnt), 0);

    // saturation: 10 consecutive load-use cycles, 3-bit counter
    set_loaduse(5'd3);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      check($sformatf("sat_%0d", i), int'(stall_cnt), (i < 7) ? i : 7);
    end

    // reset during the second WAIT cycle
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    check("rmw_pre_state", int'(state_dbg), int'(WAIT));
    reset = 1'b1;
    #1;
    check("rmw_rst_ctrl", int'(ctrl_v), int'(V_RESET));
    check("rmw_rst_err", int'(mem_err), 0);
    next_cycle();
    reset = 1'b0;
    mem_req = 1'b0;
    #1;
    check("rmw_state", int'(state_dbg), int'(RUN));
    check("rmw_wcnt", int'(wait_cnt_dbg), 0);
    check("rmw_stall_cnt", int'(stall_cnt), 0);
    check("rmw_ctrl", int'(ctrl_v), int'(V_NORMAL));

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
